// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer (master) and the RV32I datapath (slave).
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       branch_taken;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic [2:0] mem_size;
  logic       ir_we;
  logic       mdr_we;
  logic [1:0] alu_a_sel;
  logic       alu_b_sel;
  logic [1:0] alu_op;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic       pc_we;
  logic [1:0] pc_src;

  modport master (
    input  opcode, funct3, branch_taken, mem_ack,
    output mem_req, mem_we, mem_addr_sel, mem_size, ir_we, mdr_we,
           alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, pc_we, pc_src
  );
  modport slave (
    output opcode, funct3, branch_taken, mem_ack,
    input  mem_req, mem_we, mem_addr_sel, mem_size, ir_we, mdr_we,
           alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, pc_we, pc_src
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: one shared memory port, one instruction at a time,
// Mealy strobes decoded from state + IR opcode, sticky halt/illegal, retire counter.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_FENCE = 7'b0001111, OP_SYS = 7'b1110011;

  logic [2:0] nxt;
  logic       retire;
  logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic       is_fence, is_sys, is_ill;
  logic [1:0] a_sel, op_sel;
  logic       b_sel;

  always_comb begin
    {is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc} = '0;
    {is_fence, is_sys, is_ill} = '0;
    case (bus.opcode)
      OP_R:     is_r     = 1'b1;
      OP_I:     is_i     = 1'b1;
      OP_LD:    is_ld    = 1'b1;
      OP_ST:    is_st    = 1'b1;
      OP_BR:    is_br    = 1'b1;
      OP_JAL:   is_jal   = 1'b1;
      OP_JALR:  is_jalr  = 1'b1;
      OP_LUI:   is_lui   = 1'b1;
      OP_AUIPC: is_auipc = 1'b1;
      OP_FENCE: is_fence = 1'b1;
      OP_SYS:   is_sys   = 1'b1;
      default:  is_ill   = 1'b1;
    endcase
  end

  // Operand selection keyed off the same opcode the immediate generator uses.
  always_comb begin
    a_sel  = 2'd0;
    b_sel  = 1'b0;
    op_sel = 2'd0;
    if (is_r)                     op_sel = 2'd2;
    if (is_i)                     begin b_sel = 1'b1; op_sel = 2'd2; end
    if (is_ld || is_st || is_jalr) b_sel = 1'b1;
    if (is_lui)                   begin a_sel = 2'd2; b_sel = 1'b1; end
    if (is_auipc)                 begin a_sel = 2'd1; b_sel = 1'b1; end
    if (is_br)                    op_sel = 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= nxt;
      if (nxt == S_HALT)                halted  <= 1'b1;
      if (state == S_DECODE && is_ill)  illegal <= 1'b1;
      if (retire)                       instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:  if (bus.mem_ack) nxt = S_DECODE;
      S_DECODE: if (is_ill || is_sys) nxt = S_HALT;
                else if (is_fence)    nxt = S_FETCH;
                else                  nxt = S_EXEC;
      S_EXEC:   if (is_br)               nxt = S_FETCH;
                else if (is_ld || is_st) nxt = S_MEM;
                else                     nxt = S_WB;
      S_MEM:    if (bus.mem_ack) nxt = is_st ? S_FETCH : S_WB;
      S_WB:     nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_FETCH;
    endcase
  end

  always_comb begin
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.mem_size     = 3'd0;
    bus.ir_we        = 1'b0;
    bus.mdr_we       = 1'b0;
    bus.alu_a_sel    = 2'd0;
    bus.alu_b_sel    = 1'b0;
    bus.alu_op       = 2'd0;
    bus.rf_we        = 1'b0;
    bus.wb_sel       = 2'd0;
    bus.pc_we        = 1'b0;
    bus.pc_src       = 2'd0;
    retire           = 1'b0;
    // ALU controls stay at their EXEC values through MEM and WB.
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      bus.alu_a_sel = a_sel;
      bus.alu_b_sel = b_sel;
      bus.alu_op    = op_sel;
    end
    case (state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.ir_we   = bus.mem_ack;
      end
      S_DECODE: if (is_fence) begin
        bus.pc_we = 1'b1;
        retire    = 1'b1;
      end
      S_EXEC: if (is_br) begin
        bus.pc_we  = 1'b1;
        bus.pc_src = bus.branch_taken ? 2'd1 : 2'd0;
        retire     = 1'b1;
      end
      S_MEM: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        bus.mem_we       = is_st;
        bus.mem_size     = bus.funct3;
        if (bus.mem_ack) begin
          if (is_st) begin
            bus.pc_we = 1'b1;
            retire    = 1'b1;
          end else begin
            bus.mdr_we = 1'b1;
          end
        end
      end
      S_WB: begin
        bus.rf_we  = 1'b1;
        bus.wb_sel = is_ld ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
        bus.pc_we  = 1'b1;
        bus.pc_src = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        retire     = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
